// File: rtl/instruction_cache_assoc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instruction_cache_assoc: N-way set-associative read-only I-cache, FIFO   |
// | replacement per set, saturating miss counter.        Rev 1.0             |
// +--------------------------------------------------------------------------+
module instruction_cache_assoc #(
    parameter int ADDR_W = 10,
    parameter int SETS   = 4,
    parameter int WAYS   = 2,
    parameter int WORDS  = 4,
    localparam int OFF_W = $clog2(WORDS * 4),
    localparam int IDX_W = $clog2(SETS),
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W,
    localparam int BLK_W = 32 * WORDS
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [ADDR_W-1:0]       ADDRESS,
    input  logic                    READ,
    output logic [31:0]             READDATA,
    output logic                    BUSYWAIT,
    output logic [ADDR_W-OFF_W-1:0] MEM_ADDRESS,
    output logic                    MEM_READ,
    input  logic [BLK_W-1:0]        MEM_READDATA,
    input  logic                    MEM_BUSYWAIT,
    output logic [15:0]             MISS_COUNT
);
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        READ_MEM = 2'd1,
        UPDATE   = 2'd2
    } state_t;

    logic [WAYS-1:0]  valid_q [SETS];
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [BLK_W-1:0] data_q  [SETS][WAYS];
    logic [WAY_W-1:0] fifo_q  [SETS];

    state_t           state_q, state_d;
    logic [TAG_W-1:0] lat_tag_q, lat_tag_d;
    logic [IDX_W-1:0] lat_idx_q, lat_idx_d;
    logic [15:0]      miss_q, miss_d;

    logic [TAG_W-1:0]  w_tag;
    logic [IDX_W-1:0]  w_idx;
    logic [WSEL_W-1:0] w_word;
    logic              w_match;
    logic              w_hit;
    logic [WAY_W-1:0]  w_hit_way;
    logic [BLK_W-1:0]  w_hit_block;
    logic              w_set_full;
    logic [WAY_W-1:0]  w_victim;
    logic [WAY_W-1:0]  w_fifo_next;
    logic              w_fill;

    assign w_tag  = TAG_W'(ADDRESS >> (OFF_W + IDX_W));
    assign w_idx  = IDX_W'(ADDRESS >> OFF_W);
    assign w_word = (WORDS > 1) ? WSEL_W'(ADDRESS >> 2) : '0;

    always_comb begin
        w_match   = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w_idx][w] && (tag_q[w_idx][w] == w_tag)) begin
                w_match   = 1'b1;
                w_hit_way = WAY_W'(w);
            end
        end
    end

    assign w_hit       = READ & w_match;
    assign w_hit_block = data_q[w_idx][w_hit_way];
    assign READDATA    = w_hit ? w_hit_block[32*w_word +: 32] : 32'h0;

    // Descending scan so the lowest-numbered invalid way wins
    always_comb begin
        w_set_full = 1'b1;
        w_victim   = fifo_q[lat_idx_q];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[lat_idx_q][w]) begin
                w_set_full = 1'b0;
                w_victim   = WAY_W'(w);
            end
        end
    end

    assign w_fifo_next = (fifo_q[lat_idx_q] == WAY_W'(WAYS - 1)) ? '0
                                                                 : fifo_q[lat_idx_q] + 1'b1;
    assign w_fill      = (state_q == READ_MEM) && !MEM_BUSYWAIT;

    always_comb begin
        state_d   = state_q;
        lat_tag_d = lat_tag_q;
        lat_idx_d = lat_idx_q;
        miss_d    = miss_q;
        case (state_q)
            IDLE: begin
                if (READ && !w_match) begin
                    state_d   = READ_MEM;
                    lat_tag_d = w_tag;
                    lat_idx_d = w_idx;
                    miss_d    = (miss_q == 16'hFFFF) ? miss_q : miss_q + 16'd1;
                end
            end
            READ_MEM: begin
                if (!MEM_BUSYWAIT) state_d = UPDATE;
            end
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign BUSYWAIT    = (state_q == IDLE) ? (READ & ~w_match) : 1'b1;
    assign MEM_READ    = (state_q == READ_MEM);
    assign MEM_ADDRESS = MEM_READ ? {lat_tag_q, lat_idx_q} : '0;
    assign MISS_COUNT  = miss_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            lat_tag_q <= '0;
            lat_idx_q <= '0;
            miss_q    <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                fifo_q[s]  <= '0;
                for (int w = 0; w < WAYS; w++) tag_q[s][w] <= '0;
            end
        end else begin
            state_q   <= state_d;
            lat_tag_q <= lat_tag_d;
            lat_idx_q <= lat_idx_d;
            miss_q    <= miss_d;
            if (w_fill) begin
                valid_q[lat_idx_q][w_victim] <= 1'b1;
                tag_q[lat_idx_q][w_victim]   <= lat_tag_q;
                if (w_set_full) fifo_q[lat_idx_q] <= w_fifo_next;
            end
        end
    end

    // Block data is qualified by VALID, so it needs no reset
    always_ff @(posedge CLK) begin
        if (w_fill) data_q[lat_idx_q][w_victim] <= MEM_READDATA;
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_cache_assoc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_instruction_cache_assoc: vector table, corner sequences and random    |
// | fetches checked against a tag-queue cache model.     Rev 1.0             |
// +--------------------------------------------------------------------------+
module tb_instruction_cache_assoc;
    localparam int SETS = 4;
    localparam int WAYS = 2;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [9:0]   ADDRESS;
    logic         READ;
    logic [31:0]  READDATA;
    logic         BUSYWAIT;
    logic [5:0]   MEM_ADDRESS;
    logic         MEM_READ;
    logic [127:0] MEM_READDATA = '0;
    logic         MEM_BUSYWAIT = 1'b1;
    logic [15:0]  MISS_COUNT;

    int n_cmp = 0;
    int n_err = 0;
    int mem_lat = 1;
    int mem_cnt = 0;
    bit stray_resp = 1'b0;

    int model_q [SETS][$];
    int model_mc = 0;

    typedef struct {
        logic [9:0]  addr;
        int          lat;
        bit          hit;
        logic [31:0] data;
        int          mc;
    } vec_t;
    vec_t vecs [10];

    instruction_cache_assoc dut (
        .CLK(CLK), .RESET(RESET), .ADDRESS(ADDRESS), .READ(READ),
        .READDATA(READDATA), .BUSYWAIT(BUSYWAIT), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_READ(MEM_READ), .MEM_READDATA(MEM_READDATA),
        .MEM_BUSYWAIT(MEM_BUSYWAIT), .MISS_COUNT(MISS_COUNT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [127:0] blk_data(input logic [5:0] b);
        logic [127:0] d;
        for (int i = 0; i < 4; i++) d[i*32 +: 32] = (32'(b) << 16) + 32'(i) * 32'h11;
        return d;
    endfunction

    function automatic logic [31:0] exp_word(input logic [9:0] a);
        return (32'(a[9:4]) << 16) + 32'(a[3:2]) * 32'h11;
    endfunction

    // Memory: MEM_BUSYWAIT falls on the mem_lat-th cycle of a request
    always @(negedge CLK) begin
        if (stray_resp) begin
            MEM_BUSYWAIT = 1'b0;
            MEM_READDATA = {4{32'hDEADBEEF}};
        end else if (MEM_READ) begin
            mem_cnt = mem_cnt + 1;
            if (mem_cnt >= mem_lat) begin
                MEM_BUSYWAIT = 1'b0;
                MEM_READDATA = blk_data(MEM_ADDRESS);
            end else begin
                MEM_BUSYWAIT = 1'b1;
            end
        end else begin
            mem_cnt      = 0;
            MEM_BUSYWAIT = 1'b1;
        end
    end

    function automatic bit model_hit(input logic [9:0] a);
        int s = int'(a[5:4]);
        int t = int'(a[9:6]);
        foreach (model_q[s][i]) if (model_q[s][i] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_access(input logic [9:0] a);
        int s = int'(a[5:4]);
        if (!model_hit(a)) begin
            model_q[s].push_back(int'(a[9:6]));
            if (model_q[s].size() > WAYS) void'(model_q[s].pop_front());
            if (model_mc < 65535) model_mc = model_mc + 1;
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) model_q[s].delete();
        model_mc = 0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_fetch(input logic [9:0] a, input int lat, input bit eh,
                            input logic [31:0] ed, input int emc);
        int  busy;
        int  n;
        bit  seen;
        @(negedge CLK);
        ADDRESS = a;
        READ    = 1'b1;
        mem_lat = lat;
        #1;
        chk("busy_on_request", 32'(BUSYWAIT), 32'(!eh));
        if (eh) begin
            chk("hit_data", READDATA, ed);
            chk("hit_no_mem_read", 32'(MEM_READ), 32'h0);
        end else begin
            busy = 1;
            n    = 0;
            seen = 1'b0;
            while (BUSYWAIT && n < 80) begin
                @(negedge CLK);
                #1;
                n = n + 1;
                if (MEM_READ && !seen) begin
                    seen = 1'b1;
                    chk("mem_address", 32'(MEM_ADDRESS), 32'(a[9:4]));
                end
                if (BUSYWAIT) busy = busy + 1;
            end
            chk("miss_mem_read_seen", 32'(seen), 32'h1);
            chk("miss_busy_cycles", 32'(busy), 32'(lat + 2));
            chk("miss_then_hit_data", READDATA, ed);
            chk("miss_mem_read_low", 32'(MEM_READ), 32'h0);
        end
        chk("miss_count", 32'(MISS_COUNT), 32'(emc));
    endtask

    task automatic mfetch(input logic [9:0] a, input int lat);
        bit h = model_hit(a);
        do_fetch(a, lat, h, exp_word(a), h ? model_mc : model_mc + 1);
        model_access(a);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int n;
        RESET   = 1'b1;
        READ    = 1'b0;
        ADDRESS = '0;

        vecs[0] = '{10'h004, 5, 1'b0, 32'h0000_0011, 1};
        vecs[1] = '{10'h00C, 1, 1'b1, 32'h0000_0033, 1};
        vecs[2] = '{10'h040, 2, 1'b0, 32'h0004_0000, 2};
        vecs[3] = '{10'h000, 1, 1'b1, 32'h0000_0000, 2};
        vecs[4] = '{10'h040, 1, 1'b1, 32'h0004_0000, 2};
        vecs[5] = '{10'h080, 3, 1'b0, 32'h0008_0000, 3};
        vecs[6] = '{10'h044, 1, 1'b1, 32'h0004_0011, 3};
        vecs[7] = '{10'h008, 2, 1'b0, 32'h0000_0022, 4};
        vecs[8] = '{10'h084, 1, 1'b1, 32'h0008_0011, 4};
        vecs[9] = '{10'h040, 1, 1'b0, 32'h0004_0000, 5};

        repeat (2) @(negedge CLK);
        #1;
        chk("reset_busywait", 32'(BUSYWAIT), 32'h0);
        chk("reset_mem_read", 32'(MEM_READ), 32'h0);
        chk("reset_mem_address", 32'(MEM_ADDRESS), 32'h0);
        chk("reset_readdata", READDATA, 32'h0);
        chk("reset_miss_count", 32'(MISS_COUNT), 32'h0);
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();

        for (int i = 0; i < 10; i++) begin
            do_fetch(vecs[i].addr, vecs[i].lat, vecs[i].hit, vecs[i].data, vecs[i].mc);
            model_access(vecs[i].addr);
        end

        // READ dropped and ADDRESS changed mid-miss: fill uses the latched block
        @(negedge CLK);
        ADDRESS = 10'h1C0;
        READ    = 1'b1;
        mem_lat = 4;
        #1;
        chk("drop_busy_start", 32'(BUSYWAIT), 32'h1);
        @(negedge CLK);
        #1;
        chk("drop_mem_read", 32'(MEM_READ), 32'h1);
        chk("drop_mem_address", 32'(MEM_ADDRESS), 32'h1C);
        READ    = 1'b0;
        ADDRESS = 10'h3F0;
        n = 0;
        while (MEM_READ && n < 20) begin
            @(negedge CLK);
            #1;
            n = n + 1;
            if (MEM_READ) chk("drop_latched_address", 32'(MEM_ADDRESS), 32'h1C);
        end
        chk("drop_fill_in_time", 32'(n < 20), 32'h1);
        chk("drop_update_busy", 32'(BUSYWAIT), 32'h1);
        @(negedge CLK);
        #1;
        chk("drop_idle_no_stall", 32'(BUSYWAIT), 32'h0);
        chk("drop_idle_readdata", READDATA, 32'h0);
        model_access(10'h1C0);
        mfetch(10'h1C4, 1);
        mfetch(10'h3F0, 2);

        // Reset while memory is still busy
        @(negedge CLK);
        ADDRESS = 10'h100;
        READ    = 1'b1;
        mem_lat = 50;
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_pre_mem_read", 32'(MEM_READ), 32'h1);
        RESET = 1'b1;
        READ  = 1'b0;
        #1;
        chk("rst_mem_read", 32'(MEM_READ), 32'h0);
        chk("rst_busywait", 32'(BUSYWAIT), 32'h0);
        chk("rst_mem_address", 32'(MEM_ADDRESS), 32'h0);
        chk("rst_miss_count", 32'(MISS_COUNT), 32'h0);
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();
        #1;
        stray_resp = 1'b1;
        @(negedge CLK);
        #1;
        stray_resp = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            #1;
            chk("stray_mem_read", 32'(MEM_READ), 32'h0);
            chk("stray_busywait", 32'(BUSYWAIT), 32'h0);
        end
        mfetch(10'h100, 2);
        mfetch(10'h004, 1);

        // READ low: no stalls, no misses
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            ADDRESS = 10'($urandom);
            READ    = 1'b0;
            #1;
            chk("idle_busywait", 32'(BUSYWAIT), 32'h0);
            chk("idle_mem_read", 32'(MEM_READ), 32'h0);
            chk("idle_readdata", READDATA, 32'h0);
            chk("idle_miss_count", 32'(MISS_COUNT), 32'(model_mc));
        end

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                @(negedge CLK);
                ADDRESS = 10'($urandom);
                READ    = 1'b0;
                #1;
                chk("rand_idle_busywait", 32'(BUSYWAIT), 32'h0);
                chk("rand_idle_readdata", READDATA, 32'h0);
            end else begin
                mfetch({4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                        2'($urandom_range(0, 3)), 2'b00}, $urandom_range(1, 4));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
